// File: rtl/run_ctrl_pkg.sv
// Shared types for the run-control sequencer: FSM state encoding and host
// command opcodes.
package run_ctrl_pkg;

  localparam logic [1:0] OPC_LOAD = 2'd0;
  localparam logic [1:0] OPC_RUN  = 2'd1;
  localparam logic [1:0] OPC_HALT = 2'd2;
  localparam logic [1:0] OPC_STEP = 2'd3;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RST  = 3'd2,
    ST_RUN  = 3'd3,
    ST_HALT = 3'd4,
    ST_STEP = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = OPC_LOAD,
    OP_RUN  = OPC_RUN,
    OP_HALT = OPC_HALT,
    OP_STEP = OPC_STEP
  } cmd_op_e;

endpackage

// File: rtl/run_ctrl_loader.sv
// Program download engine: tracks load address and remaining byte count and
// registers one program-memory write per accepted byte.
module run_ctrl_loader
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              ld_fire,
  input  logic [DATA_W-1:0] ld_data,
  output logic              last,
  output logic              pm_wr_en,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [DATA_W-1:0] pm_wr_data
);

  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  left;

  assign last = ld_fire && (left == '0);

  // Write is registered so it lands one cycle after its handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr       <= '0;
      left       <= '0;
      pm_wr_en   <= 1'b0;
      pm_wr_addr <= '0;
      pm_wr_data <= '0;
    end else begin
      pm_wr_en <= 1'b0;
      if (start) begin
        addr <= '0;
        left <= len;
      end else if (ld_fire) begin
        pm_wr_en   <= 1'b1;
        pm_wr_addr <= addr;
        pm_wr_data <= ld_data;
        addr       <= addr + 1'b1;
        left       <= left - 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run-control sequencer: downloads a program, then sequences processor reset,
// run, halt, N-cycle step and a single PC breakpoint via the clock enable.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [7:0]        cmd_len,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              pm_wr_en,
  output logic [ADDR_W-1:0] pm_wr_addr,
  output logic [DATA_W-1:0] pm_wr_data,
  output logic              cpu_reset,
  output logic              cpu_clk_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [2:0]        state,
  output logic              busy
);

  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bp_skip_q, bp_skip_d;
  logic             cmd_fire, ld_fire, bp_hit, load_last, load_start;

  assign cmd_ready  = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALT);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign ld_ready   = (state_q == ST_LOAD);
  assign ld_fire    = ld_valid && ld_ready;
  assign bp_hit     = bp_en && (pc == bp_addr) && !bp_skip_q;
  assign load_start = cmd_fire && (cmd_op == OPC_LOAD);
  assign state      = state_q;
  assign busy       = (state_q != ST_IDLE);

  run_ctrl_loader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_loader (
    .clk        (clk),
    .reset      (reset),
    .start      (load_start),
    .len        (cmd_len),
    .ld_fire    (ld_fire),
    .ld_data    (ld_data),
    .last       (load_last),
    .pm_wr_en   (pm_wr_en),
    .pm_wr_addr (pm_wr_addr),
    .pm_wr_data (pm_wr_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bp_skip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bp_skip_q <= bp_skip_d;
    end
  end

  // bp_skip lives for exactly one cycle: the first cycle after leaving HALT
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bp_skip_d  = 1'b0;
    cpu_reset  = 1'b1;
    cpu_clk_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_op == OPC_LOAD) begin
            state_d = ST_LOAD;
          end else if (cmd_op == OPC_RUN) begin
            state_d = ST_RST;
            cnt_d   = RST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (load_last) state_d = ST_IDLE;
      end
      ST_RST: begin
        cpu_clk_en = 1'b1;
        if (cnt_q == '0) state_d = ST_RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_RUN: begin
        cpu_reset  = 1'b0;
        cpu_clk_en = !bp_hit;
        if (cmd_fire) begin
          if (cmd_op == OPC_LOAD) begin
            state_d    = ST_LOAD;
            cpu_reset  = 1'b1;
            cpu_clk_en = 1'b0;
          end else if (cmd_op == OPC_HALT) begin
            state_d = ST_HALT;
          end
        end else if (bp_hit) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        cpu_reset = 1'b0;
        if (cmd_fire) begin
          case (cmd_op)
            OPC_LOAD: state_d = ST_LOAD;
            OPC_RUN: begin
              state_d   = ST_RUN;
              bp_skip_d = 1'b1;
            end
            OPC_STEP: begin
              state_d   = ST_STEP;
              cnt_d     = cmd_len;
              bp_skip_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_STEP: begin
        cpu_reset  = 1'b0;
        cpu_clk_en = !bp_hit;
        if (bp_hit || (cnt_q == '0)) state_d = ST_HALT;
        else                         cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model with a simple PC counter.
module tb_run_controller;

  localparam int RST_CYCLES = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_len = 8'd0;
  logic       ld_valid = 1'b0;
  logic       ld_ready;
  logic [7:0] ld_data = 8'd0;
  logic       pm_wr_en;
  logic [7:0] pm_wr_addr;
  logic [7:0] pm_wr_data;
  logic       cpu_reset;
  logic       cpu_clk_en;
  logic [7:0] pc_r;
  logic       bp_en = 1'b0;
  logic [7:0] bp_addr = 8'd0;
  logic [2:0] state;
  logic       busy;

  int checks = 0;
  int errors = 0;

  run_controller #(.ADDR_W(8), .DATA_W(8), .RST_CYCLES(RST_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .pm_wr_en   (pm_wr_en),
    .pm_wr_addr (pm_wr_addr),
    .pm_wr_data (pm_wr_data),
    .cpu_reset  (cpu_reset),
    .cpu_clk_en (cpu_clk_en),
    .pc         (pc_r),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .state      (state),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Modes use the published state numbers: 0 idle, 1 load, 2 rst, 3 run, 4 halt, 5 step
  int         m_mode = 0;
  int         m_rem = 0;
  int         m_left = 0;
  int         m_la = 0;
  bit         m_skip = 1'b0;
  logic       m_wr_en = 1'b0;
  logic [7:0] m_wr_addr = 8'd0;
  logic [7:0] m_wr_data = 8'd0;

  function automatic bit e_fire();
    return cmd_valid && (m_mode == 0 || m_mode == 3 || m_mode == 4);
  endfunction

  function automatic bit e_bp();
    return bp_en && (pc_r == bp_addr) && !m_skip;
  endfunction

  function automatic bit e_rst();
    return (m_mode <= 2) || (m_mode == 3 && e_fire() && cmd_op == 2'd0);
  endfunction

  function automatic bit e_en();
    if (m_mode == 2) return 1'b1;
    if (m_mode == 3) return !(e_fire() && cmd_op == 2'd0) && !e_bp();
    if (m_mode == 5) return !e_bp();
    return 1'b0;
  endfunction

  // Model update plus a minimal processor PC that counts when enabled
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 0; m_rem <= 0; m_left <= 0; m_la <= 0; m_skip <= 1'b0;
      m_wr_en <= 1'b0; m_wr_addr <= 8'd0; m_wr_data <= 8'd0;
      pc_r <= 8'd0;
    end else begin
      if (e_en()) pc_r <= e_rst() ? 8'd0 : pc_r + 8'd1;
      m_wr_en <= 1'b0;
      m_skip  <= 1'b0;
      case (m_mode)
        0: if (e_fire()) begin
             if (cmd_op == 2'd0) begin m_mode <= 1; m_left <= int'(cmd_len); m_la <= 0; end
             else if (cmd_op == 2'd1) begin m_mode <= 2; m_rem <= RST_CYCLES; end
           end
        1: if (ld_valid) begin
             m_wr_en <= 1'b1; m_wr_addr <= 8'(m_la); m_wr_data <= ld_data;
             m_la <= (m_la + 1) % 256;
             if (m_left == 0) m_mode <= 0; else m_left <= m_left - 1;
           end
        2: begin
             if (m_rem == 1) m_mode <= 3;
             m_rem <= m_rem - 1;
           end
        3: if (e_fire()) begin
             if (cmd_op == 2'd0) begin m_mode <= 1; m_left <= int'(cmd_len); m_la <= 0; end
             else if (cmd_op == 2'd2) m_mode <= 4;
           end else if (e_bp()) m_mode <= 4;
        4: if (e_fire()) begin
             if (cmd_op == 2'd0) begin m_mode <= 1; m_left <= int'(cmd_len); m_la <= 0; end
             else if (cmd_op == 2'd1) begin m_mode <= 3; m_skip <= 1'b1; end
             else if (cmd_op == 2'd3) begin m_mode <= 5; m_rem <= int'(cmd_len) + 1; m_skip <= 1'b1; end
           end
        5: if (e_bp() || m_rem == 1) m_mode <= 4; else m_rem <= m_rem - 1;
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("state", 32'(state), 32'(m_mode));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0 || m_mode == 3 || m_mode == 4));
    chk("ld_ready", 32'(ld_ready), 32'(m_mode == 1));
    chk("cpu_reset", 32'(cpu_reset), 32'(e_rst()));
    chk("cpu_clk_en", 32'(cpu_clk_en), 32'(e_en()));
    chk("pm_wr_en", 32'(pm_wr_en), 32'(m_wr_en));
    chk("pm_wr_addr", 32'(pm_wr_addr), 32'(m_wr_addr));
    chk("pm_wr_data", 32'(pm_wr_data), 32'(m_wr_data));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("cmd_accept_timeout", 32'(n), 32'd0);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ld_bytes [4];
    int n;
    int cnt;
    ld_bytes = '{8'hC8, 8'h12, 8'hD8, 8'hE0};

    // Power-up reset held for three cycles
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("por_state", 32'(state), 32'd0);
    chk("por_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("por_clk_en", 32'(cpu_clk_en), 32'd0);
    chk("por_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("por_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();

    // Program download with gapped byte strobes
    send_cmd(2'd0, 8'd3);
    chk("load_state", 32'(state), 32'd1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = ld_bytes[i];
      tick();
      ld_valid = 1'b0;
      chk("load_wr_en", 32'(pm_wr_en), 32'd1);
      chk("load_wr_addr", 32'(pm_wr_addr), 32'(i));
      chk("load_wr_data", 32'(pm_wr_data), 32'(ld_bytes[i]));
      chk("load_state_after_byte", 32'(state), (i == 3) ? 32'd0 : 32'd1);
      tick();
      chk("load_wr_en_pulse", 32'(pm_wr_en), 32'd0);
    end

    // Run from idle through the reset sequence into a breakpoint
    bp_en   = 1'b1;
    bp_addr = 8'h05;
    send_cmd(2'd1, 8'd0);
    chk("rst1_state", 32'(state), 32'd2);
    chk("rst1_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst1_clk_en", 32'(cpu_clk_en), 32'd1);
    tick();
    chk("rst2_state", 32'(state), 32'd2);
    chk("rst2_clk_en", 32'(cpu_clk_en), 32'd1);
    tick();
    chk("run_state", 32'(state), 32'd3);
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("run_pc_start", 32'(pc_r), 32'd0);
    n = 0;
    while (pc_r != 8'h05 && n < 50) begin tick(); n++; end
    chk("bp_reach", 32'(pc_r), 32'h05);
    chk("bp_cycle_state", 32'(state), 32'd3);
    chk("bp_cycle_clk_en", 32'(cpu_clk_en), 32'd0);
    tick();
    chk("bp_halt_state", 32'(state), 32'd4);
    chk("model_halt_mode", 32'(m_mode), 32'd4);
    tick(); tick();
    chk("bp_pc_frozen", 32'(pc_r), 32'h05);

    // Step three cycles from the breakpoint
    send_cmd(2'd3, 8'd2);
    chk("step_state", 32'(state), 32'd5);
    cnt = 0;
    n = 0;
    while (state == 3'd5 && n < 50) begin
      if (cpu_clk_en) cnt++;
      tick();
      n++;
    end
    chk("step_enabled_cycles", 32'(cnt), 32'd3);
    chk("step_pc", 32'(pc_r), 32'h08);
    chk("step_end_state", 32'(state), 32'd4);

    send_cmd(2'd1, 8'd0);
    repeat (5) tick();
    chk("resume_state", 32'(state), 32'd3);
    chk("resume_pc", 32'(pc_r), 32'd13);

    // Halt on a new breakpoint, then resume directly off it
    bp_addr = pc_r + 8'd2;
    n = 0;
    while (state != 3'd4 && n < 50) begin tick(); n++; end
    chk("bp2_pc", 32'(pc_r), 32'd15);
    send_cmd(2'd1, 8'd0);
    chk("skip_clk_en", 32'(cpu_clk_en), 32'd1);
    tick();
    chk("skip_state", 32'(state), 32'd3);
    chk("skip_pc", 32'(pc_r), 32'd16);

    // Reset in the middle of a download, then a fresh one-byte download
    send_cmd(2'd0, 8'd3);
    ld_valid = 1'b1;
    ld_data  = 8'h3C;
    tick();
    ld_data  = 8'h4D;
    tick();
    ld_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midload_state", 32'(state), 32'd0);
    chk("midload_wr_en", 32'(pm_wr_en), 32'd0);
    chk("midload_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    send_cmd(2'd0, 8'd0);
    ld_valid = 1'b1;
    ld_data  = 8'hA5;
    tick();
    ld_valid = 1'b0;
    chk("reload_wr_en", 32'(pm_wr_en), 32'd1);
    chk("reload_wr_addr", 32'(pm_wr_addr), 32'd0);
    chk("reload_wr_data", 32'(pm_wr_data), 32'hA5);
    chk("reload_state", 32'(state), 32'd0);

    // Randomized traffic, checked cycle by cycle by the model
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) != 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_len   = 8'($urandom_range(0, 7));
      ld_valid  = ($urandom_range(0, 1) == 1);
      ld_data   = 8'($urandom);
      bp_en     = ($urandom_range(0, 3) != 0);
      bp_addr   = pc_r + 8'($urandom_range(0, 8));
      tick();
    end
    reset     = 1'b1;
    cmd_valid = 1'b0;
    ld_valid  = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
